// File: rtl/uart_host_link.sv
// Host-side UART packet framer/parser: turns typed host requests into 2/3-byte UART
// packets and folds the chip's 2-byte response packets into one typed output stream.
module uart_host_link #(
  parameter int DATA_WIDTH = 8,
  parameter int RX_TIMEOUT = 1024,
  parameter int ERR_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] tx_req_type,
  input  logic [DATA_WIDTH-1:0] tx_req_addr,
  input  logic [DATA_WIDTH-1:0] tx_req_data,
  input  logic                  tx_req_valid,
  output logic                  tx_req_ready,
  output logic [DATA_WIDTH-1:0] uart_tx_tdata,
  output logic                  uart_tx_tvalid,
  input  logic                  uart_tx_tready,
  output logic                  uart_tx_tlast,
  input  logic [DATA_WIDTH-1:0] uart_rx_tdata,
  input  logic                  uart_rx_tvalid,
  output logic                  uart_rx_tready,
  output logic [DATA_WIDTH-1:0] rx_out_type,
  output logic [DATA_WIDTH-1:0] rx_out_data,
  output logic                  rx_out_valid,
  input  logic                  rx_out_ready,
  output logic [ERR_W-1:0]      rx_err_count
);

  // Every stream uses valid/ready: a transfer happens on a clock edge where both are high;
  // a source holds its payload stable while valid is high and ready is low.

  localparam int TO_W = $clog2(RX_TIMEOUT);

  typedef enum logic [1:0] {T_IDLE, T_HDR, T_ADDR, T_DATA} tx_state_t;
  typedef enum logic [1:0] {R_HDR, R_DATA, R_OUT} rx_state_t;

  tx_state_t tx_state, tx_state_nxt;
  rx_state_t rx_state, rx_state_nxt;

  logic [DATA_WIDTH-1:0] tx_type_q, tx_addr_q, tx_data_q;
  logic [DATA_WIDTH-1:0] rx_type_q, rx_data_q;
  logic [TO_W-1:0]       to_cnt;
  logic [ERR_W-1:0]      err_cnt;
  logic                  hdr_ok, timeout, err_inc;

  assign uart_tx_tlast = 1'b0;
  assign rx_out_type   = rx_type_q;
  assign rx_out_data   = rx_data_q;
  assign rx_err_count  = err_cnt;

  // ---------------- TX framer ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state <= T_IDLE;
    end else begin
      tx_state <= tx_state_nxt;
    end
    if (tx_req_valid && tx_req_ready) begin
      tx_type_q <= tx_req_type;
      tx_addr_q <= tx_req_addr;
      tx_data_q <= tx_req_data;
    end
  end

  always_comb begin
    tx_state_nxt   = tx_state;
    tx_req_ready   = 1'b0;
    uart_tx_tvalid = 1'b0;
    uart_tx_tdata  = '0;
    case (tx_state)
      T_IDLE: begin
        tx_req_ready = 1'b1;
        if (tx_req_valid) tx_state_nxt = T_HDR;
      end
      T_HDR: begin
        uart_tx_tvalid = 1'b1;
        uart_tx_tdata  = tx_type_q;
        // Only INFO carries a field index; every other code, including unknown ones, is 2 bytes.
        if (uart_tx_tready)
          tx_state_nxt = (tx_type_q == DATA_WIDTH'(7)) ? T_ADDR : T_DATA;
      end
      T_ADDR: begin
        uart_tx_tvalid = 1'b1;
        uart_tx_tdata  = tx_addr_q;
        if (uart_tx_tready) tx_state_nxt = T_DATA;
      end
      T_DATA: begin
        uart_tx_tvalid = 1'b1;
        uart_tx_tdata  = tx_data_q;
        if (uart_tx_tready) tx_state_nxt = T_IDLE;
      end
      default: tx_state_nxt = T_IDLE;
    endcase
  end

  // ---------------- RX parser ----------------
  // The chip only ever answers with PARROT, ETH_FRAME_OUT, REMAINING_LAYER or BRAIN_STATUS.
  assign hdr_ok  = (uart_rx_tdata == DATA_WIDTH'(0)) || (uart_rx_tdata == DATA_WIDTH'(2)) ||
                   (uart_rx_tdata == DATA_WIDTH'(3)) || (uart_rx_tdata == DATA_WIDTH'(5));
  assign timeout = (rx_state == R_DATA) && !uart_rx_tvalid &&
                   (to_cnt == TO_W'(RX_TIMEOUT - 1));

  always_comb begin
    rx_state_nxt   = rx_state;
    uart_rx_tready = 1'b0;
    rx_out_valid   = 1'b0;
    err_inc        = 1'b0;
    case (rx_state)
      R_HDR: begin
        uart_rx_tready = 1'b1;
        if (uart_rx_tvalid) begin
          if (hdr_ok) rx_state_nxt = R_DATA;
          else        err_inc      = 1'b1;
        end
      end
      R_DATA: begin
        uart_rx_tready = 1'b1;
        if (uart_rx_tvalid) begin
          rx_state_nxt = R_OUT;
        end else if (timeout) begin
          rx_state_nxt = R_HDR;
          err_inc      = 1'b1;
        end
      end
      R_OUT: begin
        rx_out_valid = 1'b1;
        if (rx_out_ready) rx_state_nxt = R_HDR;
      end
      default: rx_state_nxt = R_HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state <= R_HDR;
      to_cnt   <= '0;
      err_cnt  <= '0;
    end else begin
      rx_state <= rx_state_nxt;
      // Counter is zero everywhere outside an idle stretch of R_DATA, so entry starts at 0.
      if (rx_state == R_DATA && !uart_rx_tvalid && !timeout) to_cnt <= to_cnt + TO_W'(1);
      else                                                    to_cnt <= '0;
      if (err_inc && (err_cnt != {ERR_W{1'b1}})) err_cnt <= err_cnt + ERR_W'(1);
    end
    if (rx_state == R_HDR && uart_rx_tvalid && hdr_ok) rx_type_q <= uart_rx_tdata;
    if (rx_state == R_DATA && uart_rx_tvalid)          rx_data_q <= uart_rx_tdata;
  end

endmodule

// File: tb/tb_uart_host_link.sv
// Directed bench for uart_host_link: TX framing, stalls, RX parsing, resync, timeout,
// error saturation and mid-packet reset.
module tb_uart_host_link;
  localparam int RX_TIMEOUT = 16;
  localparam int ERR_W      = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] tx_req_type, tx_req_addr, tx_req_data;
  logic tx_req_valid, tx_req_ready;
  logic [7:0] uart_tx_tdata;
  logic uart_tx_tvalid, uart_tx_tready, uart_tx_tlast;
  logic [7:0] uart_rx_tdata;
  logic uart_rx_tvalid, uart_rx_tready;
  logic [7:0] rx_out_type, rx_out_data;
  logic rx_out_valid, rx_out_ready;
  logic [ERR_W-1:0] rx_err_count;

  uart_host_link #(.DATA_WIDTH(8), .RX_TIMEOUT(RX_TIMEOUT), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .tx_req_type(tx_req_type), .tx_req_addr(tx_req_addr), .tx_req_data(tx_req_data),
    .tx_req_valid(tx_req_valid), .tx_req_ready(tx_req_ready),
    .uart_tx_tdata(uart_tx_tdata), .uart_tx_tvalid(uart_tx_tvalid),
    .uart_tx_tready(uart_tx_tready), .uart_tx_tlast(uart_tx_tlast),
    .uart_rx_tdata(uart_rx_tdata), .uart_rx_tvalid(uart_rx_tvalid),
    .uart_rx_tready(uart_rx_tready),
    .rx_out_type(rx_out_type), .rx_out_data(rx_out_data),
    .rx_out_valid(rx_out_valid), .rx_out_ready(rx_out_ready),
    .rx_err_count(rx_err_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int busy_cycles, ready_in_busy, stall_changes;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // ---------------- drivers ----------------
  task automatic tx_run(input logic [7:0] t, input logic [7:0] a, input logic [7:0] d,
                        input bit toggle);
    bit acc, hs, prev_stall, done;
    logic tr;
    logic [7:0] prev_data;
    got_q.delete();
    busy_cycles = 0; ready_in_busy = 0; stall_changes = 0;
    tx_req_type = t; tx_req_addr = a; tx_req_data = d; tx_req_valid = 1'b1;
    uart_tx_tready = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) begin
      acc = tx_req_ready;
      step();
    end
    tx_req_valid = 1'b0;
    if (!acc) begin
      checks++; failures++;
      $display("FAIL tx_accept_timeout got=0 exp=1");
    end
    prev_stall = 1'b0; prev_data = '0; tr = 1'b0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (!uart_tx_tvalid) begin
        done = 1'b1;
      end else begin
        busy_cycles++;
        if (tx_req_ready) ready_in_busy++;
        if (prev_stall && uart_tx_tdata !== prev_data) stall_changes++;
        uart_tx_tready = toggle ? tr : 1'b1;
        hs = uart_tx_tready;
        if (hs) got_q.push_back(uart_tx_tdata);
        prev_stall = !hs;
        prev_data  = uart_tx_tdata;
        step();
        tr = ~tr;
      end
    end
    uart_tx_tready = 1'b1;
    if (!done) begin
      checks++; failures++;
      $display("FAIL tx_packet_timeout got=busy exp=idle");
    end
  endtask

  task automatic rx_send(input logic [7:0] b);
    bit hs;
    uart_rx_tdata = b; uart_rx_tvalid = 1'b1;
    hs = 1'b0;
    for (int i = 0; i < 50 && !hs; i++) begin
      hs = uart_rx_tready;
      step();
    end
    uart_rx_tvalid = 1'b0;
    if (!hs) begin
      checks++; failures++;
      $display("FAIL rx_send_timeout byte=%h got=stalled exp=accepted", b);
    end
  endtask

  task automatic rx_consume();
    rx_out_ready = 1'b1;
    step();
    rx_out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    tx_req_type = '0; tx_req_addr = '0; tx_req_data = '0; tx_req_valid = 1'b0;
    uart_tx_tready = 1'b1; uart_rx_tdata = '0; uart_rx_tvalid = 1'b0; rx_out_ready = 1'b0;
    step(); step();
    checks++; if (tx_req_ready !== 1'b1) begin failures++; $display("FAIL reset_tx_req_ready got=%b exp=1", tx_req_ready); end
    checks++; if (uart_tx_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tx_tvalid got=%b exp=0", uart_tx_tvalid); end
    checks++; if (uart_rx_tready !== 1'b1) begin failures++; $display("FAIL reset_rx_tready got=%b exp=1", uart_rx_tready); end
    checks++; if (rx_out_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_out_valid got=%b exp=0", rx_out_valid); end
    checks++; if (rx_err_count !== 3'd0) begin failures++; $display("FAIL reset_err_count got=%0d exp=0", rx_err_count); end
    checks++; if (uart_tx_tlast !== 1'b0) begin failures++; $display("FAIL reset_tlast got=%b exp=0", uart_tx_tlast); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_instruction();
    exp_q = '{8'h04, 8'h5A};
    tx_run(8'h04, 8'hEE, 8'h5A, 1'b0);
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL instr_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL instr_byte%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++; if (busy_cycles != 2) begin failures++; $display("FAIL instr_busy_cycles got=%0d exp=2", busy_cycles); end
    checks++; if (ready_in_busy != 0) begin failures++; $display("FAIL instr_ready_while_busy got=%0d exp=0", ready_in_busy); end
    checks++; if (tx_req_ready !== 1'b1) begin failures++; $display("FAIL instr_ready_after got=%b exp=1", tx_req_ready); end
  endtask

  task automatic test_info_stall();
    exp_q = '{8'h07, 8'h0C, 8'hC0};
    tx_run(8'h07, 8'h0C, 8'hC0, 1'b1);
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL info_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL info_byte%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++; if (stall_changes != 0) begin failures++; $display("FAIL info_stall_stable got=%0d exp=0", stall_changes); end
    checks++; if (busy_cycles != 6) begin failures++; $display("FAIL info_busy_cycles got=%0d exp=6", busy_cycles); end
  endtask

  task automatic test_two_byte_types();
    exp_q = '{8'h9A, 8'h01};
    tx_run(8'h9A, 8'hEE, 8'h01, 1'b0);
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL verbatim_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL verbatim_byte%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    exp_q = '{8'h03, 8'h77};
    tx_run(8'h03, 8'hEE, 8'h77, 1'b1);
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL type3_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL type3_byte%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_rx_hold();
    rx_send(8'h05);
    rx_send(8'h33);
    for (int i = 0; i < 5; i++) begin
      checks++; if (rx_out_valid !== 1'b1) begin failures++; $display("FAIL hold_valid c%0d got=%b exp=1", i, rx_out_valid); end
      checks++; if (rx_out_type !== 8'h05) begin failures++; $display("FAIL hold_type c%0d got=%h exp=05", i, rx_out_type); end
      checks++; if (rx_out_data !== 8'h33) begin failures++; $display("FAIL hold_data c%0d got=%h exp=33", i, rx_out_data); end
      checks++; if (uart_rx_tready !== 1'b0) begin failures++; $display("FAIL hold_rx_tready c%0d got=%b exp=0", i, uart_rx_tready); end
      step();
    end
    rx_consume();
    checks++; if (rx_out_valid !== 1'b0) begin failures++; $display("FAIL hold_valid_after got=%b exp=0", rx_out_valid); end
    checks++; if (uart_rx_tready !== 1'b1) begin failures++; $display("FAIL hold_tready_after got=%b exp=1", uart_rx_tready); end
  endtask

  task automatic test_rx_resync();
    do_reset();
    rx_send(8'h09);
    checks++; if (rx_err_count !== 3'd1) begin failures++; $display("FAIL resync_err got=%0d exp=1", rx_err_count); end
    checks++; if (rx_out_valid !== 1'b0) begin failures++; $display("FAIL resync_no_out got=%b exp=0", rx_out_valid); end
    rx_send(8'h02);
    rx_send(8'h11);
    checks++; if (rx_out_valid !== 1'b1) begin failures++; $display("FAIL resync_valid got=%b exp=1", rx_out_valid); end
    checks++; if (rx_out_type !== 8'h02) begin failures++; $display("FAIL resync_type got=%h exp=02", rx_out_type); end
    checks++; if (rx_out_data !== 8'h11) begin failures++; $display("FAIL resync_data got=%h exp=11", rx_out_data); end
    rx_consume();
  endtask

  task automatic test_rx_timeout();
    do_reset();
    rx_send(8'h03);
    repeat (RX_TIMEOUT - 1) step();
    checks++; if (rx_err_count !== 3'd0) begin failures++; $display("FAIL timeout_early_err got=%0d exp=0", rx_err_count); end
    step();
    checks++; if (rx_err_count !== 3'd1) begin failures++; $display("FAIL timeout_err got=%0d exp=1", rx_err_count); end
    checks++; if (rx_out_valid !== 1'b0) begin failures++; $display("FAIL timeout_no_out got=%b exp=0", rx_out_valid); end
    rx_send(8'h00);
    rx_send(8'hAB);
    checks++; if (rx_out_valid !== 1'b1) begin failures++; $display("FAIL timeout_next_valid got=%b exp=1", rx_out_valid); end
    checks++; if (rx_out_type !== 8'h00) begin failures++; $display("FAIL timeout_next_type got=%h exp=00", rx_out_type); end
    checks++; if (rx_out_data !== 8'hAB) begin failures++; $display("FAIL timeout_next_data got=%h exp=ab", rx_out_data); end
    rx_consume();
    // Data arriving on the last cycle before the timeout still completes the packet.
    rx_send(8'h05);
    repeat (RX_TIMEOUT - 1) step();
    rx_send(8'h44);
    checks++; if (rx_err_count !== 3'd1) begin failures++; $display("FAIL late_data_err got=%0d exp=1", rx_err_count); end
    checks++; if (rx_out_valid !== 1'b1) begin failures++; $display("FAIL late_data_valid got=%b exp=1", rx_out_valid); end
    checks++; if (rx_out_type !== 8'h05) begin failures++; $display("FAIL late_data_type got=%h exp=05", rx_out_type); end
    checks++; if (rx_out_data !== 8'h44) begin failures++; $display("FAIL late_data_data got=%h exp=44", rx_out_data); end
    rx_consume();
  endtask

  task automatic test_err_saturate();
    logic [7:0] bad [10] = '{8'h01, 8'h04, 8'h06, 8'h07, 8'hFF, 8'h08, 8'h80, 8'h01, 8'h04, 8'h06};
    do_reset();
    for (int i = 0; i < 7; i++) rx_send(bad[i]);
    checks++; if (rx_err_count !== 3'd7) begin failures++; $display("FAIL sat_reach got=%0d exp=7", rx_err_count); end
    for (int i = 7; i < 10; i++) rx_send(bad[i]);
    checks++; if (rx_err_count !== 3'd7) begin failures++; $display("FAIL sat_hold got=%0d exp=7", rx_err_count); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    rx_send(8'h01);
    rx_send(8'h02);
    tx_req_type = 8'h07; tx_req_addr = 8'h0C; tx_req_data = 8'hC0; tx_req_valid = 1'b1;
    uart_tx_tready = 1'b1;
    step();
    tx_req_valid = 1'b0;
    step();
    checks++; if (uart_tx_tdata !== 8'h0C) begin failures++; $display("FAIL midrst_in_addr got=%h exp=0c", uart_tx_tdata); end
    checks++; if (rx_err_count !== 3'd1) begin failures++; $display("FAIL midrst_err_before got=%0d exp=1", rx_err_count); end
    rst_n = 1'b0;
    step();
    checks++; if (uart_tx_tvalid !== 1'b0) begin failures++; $display("FAIL midrst_tx_tvalid got=%b exp=0", uart_tx_tvalid); end
    checks++; if (rx_out_valid !== 1'b0) begin failures++; $display("FAIL midrst_rx_out_valid got=%b exp=0", rx_out_valid); end
    checks++; if (tx_req_ready !== 1'b1) begin failures++; $display("FAIL midrst_tx_req_ready got=%b exp=1", tx_req_ready); end
    checks++; if (rx_err_count !== 3'd0) begin failures++; $display("FAIL midrst_err got=%0d exp=0", rx_err_count); end
    rst_n = 1'b1;
    rx_send(8'h00);
    rx_send(8'h5A);
    checks++; if (rx_out_type !== 8'h00 || rx_out_data !== 8'h5A) begin
      failures++; $display("FAIL midrst_rx_resume got=%h/%h exp=00/5a", rx_out_type, rx_out_data);
    end
    rx_consume();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_instruction();
    test_info_stall();
    test_two_byte_types();
    test_rx_hold();
    test_rx_resync();
    test_rx_timeout();
    test_err_saturate();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
